pipe_ex_out_buf: RTL

//  Downstream companion to the 3-stage arithmetic pipeline F=(A+B+C-D)*D.
//  - The pipeline has no stall and no valid. This block tracks which issue slots carry real operands.
//  - It captures F for those slots into a FIFO and presents results on a valid/ready output.
//  - It grants issue credits so that the FIFO can never overflow under consumer backpressure.

---
 rtl/pipe_ex_out_buf.sv | 79 +++++++
 1 files changed

// File: rtl/pipe_ex_out_buf.sv
// Result buffer and credit issuer behind the no-stall F=(A+B+C-D)*D pipeline.
// Optional check logic (err_sticky output) is enabled by defining PIPE_OUT_BUF_CHK_EN.
module pipe_ex_out_buf #(
  parameter int N     = 100,
  parameter int DEPTH = 8,
  parameter int LAT   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     issue_ok,
  input  logic [N-1:0]             f,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   level
`ifdef PIPE_OUT_BUF_CHK_EN
  ,
  output logic                     err_sticky
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [LAT-1:0] vd;
  logic [AW:0]    reserved;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [N-1:0]   mem [DEPTH];
  logic           accept;
  logic           push;
  logic           pop;

  assign accept    = in_valid && issue_ok;
  assign push      = vd[LAT-1];
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  // Credits count both buffered results and those still inside the pipeline,
  // so a push can never find the FIFO full without a matching pop.
  assign issue_ok  = (reserved < (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      vd       <= '0;
      reserved <= '0;
      level    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      vd       <= (vd << 1) | LAT'(accept);
      reserved <= reserved + (AW+1)'(accept) - (AW+1)'(pop);
      level    <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (push) begin
        mem[wr_ptr] <= f;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef PIPE_OUT_BUF_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if ((in_valid && !issue_ok) ||
                 (push && !pop && (level == (AW+1)'(DEPTH)))) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule
